// File: rtl/csr_pkg.sv
// Shared constants and helpers for the machine-mode CSR / interrupt unit.
// Optional mcycle counter is enabled by defining CSR_MCYCLE_EN.
package csr_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CSR_AW = 12;

  // CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MIP     = 12'h344;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH = 12'hB80;

  // Bit positions inside mstatus / mie / mip
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  // Interrupt bit set, cause 11 (machine external interrupt)
  localparam logic [XLEN-1:0] MCAUSE_MEXT = 32'h8000_000B;

  // func3[1:0] of the CSR instruction
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Read-modify-write result for a CSR operation
  function automatic logic [XLEN-1:0] csr_apply(input csr_op_e op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wval);
    logic [XLEN-1:0] res;
    case (op)
      CSR_OP_WRITE: res = wval;
      CSR_OP_SET:   res = old_val | wval;
      CSR_OP_CLEAR: res = old_val & ~wval;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchronizer for an asynchronous interrupt line followed by a
// rising-edge detector producing a single-cycle pulse.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_irq_async,
  output logic o_irq_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_irq_d;
  logic                   w_irq_s;

  assign w_irq_s = r_sync[SYNC_STAGES-1];

  // Shift the async line through the synchronizer and keep one delayed copy
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_irq_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_irq_async};
      r_irq_d <= w_irq_s;
    end
  end

  assign o_irq_rise = w_irq_s & ~r_irq_d;

endmodule

// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file and external-interrupt controller for the multicycle
// OTTER core. Define CSR_MCYCLE_EN to add the 64-bit mcycle counter.
module csr_intr_unit
  import csr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        irq_async,
  input  logic        csr_WE,
  input  logic        int_taken,
  input  logic        mret_exec,
  input  logic [2:0]  func3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] csr_rd,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        intr
);

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_mie_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_pending;
`ifdef CSR_MCYCLE_EN
  logic [63:0] r_mcycle;
`endif

  logic        w_irq_rise;
  csr_op_e     w_op;
  logic [31:0] w_new;
  logic        w_csr_wr;
  logic        w_unused_func3;

  // func3[2] only selects register vs immediate source, resolved upstream
  assign w_unused_func3 = func3[2];

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync_edge (
    .i_clk       (clk),
    .i_rst_n     (RST_N),
    .i_irq_async (irq_async),
    .o_irq_rise  (w_irq_rise)
  );

  // Combinational read of the addressed CSR from current register state
  always_comb begin
    csr_rd = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rd[MSTATUS_MIE_BIT]  = r_mstatus_mie;
        csr_rd[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
      end
      CSR_MIE:     csr_rd[MIE_MEIE_BIT] = r_mie_meie;
      CSR_MTVEC:   csr_rd = r_mtvec;
      CSR_MEPC:    csr_rd = r_mepc;
      CSR_MCAUSE:  csr_rd = r_mcause;
      CSR_MIP:     csr_rd[MIP_MEIP_BIT] = r_pending;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:  csr_rd = r_mcycle[31:0];
      CSR_MCYCLEH: csr_rd = r_mcycle[63:32];
`endif
      default:     csr_rd = '0;
    endcase
  end

  // Software write only lands when no higher-priority strobe is active
  assign w_op     = csr_op_e'(func3[1:0]);
  assign w_new    = csr_apply(w_op, csr_rd, wdata);
  assign w_csr_wr = csr_WE & (w_op != CSR_OP_NONE) & ~int_taken & ~mret_exec;

  // Architectural CSR updates: trap entry, then mret, then software write
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mtvec        <= MTVEC_RESET;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else if (int_taken) begin
      r_mepc         <= {pc[31:2], 2'b00};
      r_mcause       <= MCAUSE_MEXT;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (mret_exec) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          r_mstatus_mie  <= w_new[MSTATUS_MIE_BIT];
          r_mstatus_mpie <= w_new[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    r_mie_meie <= w_new[MIE_MEIE_BIT];
        CSR_MTVEC:  r_mtvec    <= {w_new[31:2], 2'b00};
        CSR_MEPC:   r_mepc     <= {w_new[31:2], 2'b00};
        CSR_MCAUSE: r_mcause   <= w_new;
        default:    ;
      endcase
    end
  end

  // Pending latch: a new edge wins over the clear from trap entry
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_pending <= 1'b0;
    end else if (w_irq_rise) begin
      r_pending <= 1'b1;
    end else if (int_taken) begin
      r_pending <= 1'b0;
    end
  end

`ifdef CSR_MCYCLE_EN
  // Free-running cycle counter; a write to either half replaces it for that cycle
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_mcycle <= '0;
    end else if (w_csr_wr && (csr_addr == CSR_MCYCLE)) begin
      r_mcycle[31:0] <= w_new;
    end else if (w_csr_wr && (csr_addr == CSR_MCYCLEH)) begin
      r_mcycle[63:32] <= w_new;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end
`endif

  assign intr      = r_pending & r_mstatus_mie & r_mie_meie;
  assign mtvec_out = r_mtvec;
  assign mepc_out  = r_mepc;

endmodule

// File: doc/csr_intr_unit.md
Name: csr_intr_unit

Overview:
- Machine-mode CSR file and interrupt controller for the multicycle OTTER core.
- Sits beside the control FSM:
  - consumes its csr_WE, int_taken and mret_exec strobes;
  - produces the gated intr request the FSM samples in EX/WB.
- Supplies csr_rd to the register-file write mux, and mtvec/mepc to the PC-source mux.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on irq_async (legal range 2..4).
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock
- RST_N  in  1  synchronous active-low reset
- irq_async  in  1  external interrupt, asynchronous to clk
- csr_WE  in  1  CSR write strobe from control FSM (EX state)
- int_taken  in  1  interrupt-entry strobe from control FSM (INTR state)
- mret_exec  in  1  mret strobe from control FSM
- func3  in  3  ir[14:12]; [1:0]: 01=write, 10=set, 11=clear
- csr_addr  in  12  ir[31:20]
- wdata  in  32  rs1 value or zero-extended zimm, selected upstream
- pc  in  32  PC of the instruction being interrupted
- csr_rd  out  32  current value of addressed CSR (combinational)
- mtvec_out  out  32  trap vector
- mepc_out  out  32  return address
- intr  out  1  gated interrupt request to control FSM

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low (RST_N). Every register updates only on posedge clk.
- Values on RST_N=0:
  - mstatus.MIE=0, mstatus.MPIE=0;
  - mie.MEIE=0;
  - mtvec=MTVEC_RESET;
  - mepc=0, mcause=0;
  - synchronizer flops=0, edge flop=0, pending=0.
  - Outputs follow: intr=0, mtvec_out=MTVEC_RESET, mepc_out=0.
  - Reset asserted mid-operation discards any pending interrupt.
- CSR map:
  - mstatus 0x300: bits 3=MIE, 7=MPIE; all other bits read 0.
  - mie 0x304: bit 11=MEIE.
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only, bit 11 = pending.
  - Unmapped addresses read 0; writes to them are ignored.
- Read: csr_rd is a combinational function of csr_addr and the pre-edge register value. This gives csrrw/csrrs/csrrc the old value for rd.
- Write (csr_WE=1), new value computed from wdata:
  - func3[1:0]=01: new=wdata;
  - 10: new=old|wdata;
  - 11: new=old&~wdata;
  - 00: no write.
  - The write takes effect at the edge.
- Interrupt entry (int_taken=1):
  - mepc<=pc;
  - mcause<=32'h8000_000B;
  - MPIE<=MIE, MIE<=0;
  - pending<=0.
- mret (mret_exec=1): MIE<=MPIE, MPIE<=1.
- Priority on simultaneous strobes: int_taken > mret_exec > csr_WE. The lower-priority update is dropped entirely.
- Interrupt path:
  - irq_async passes through SYNC_STAGES flops to give irq_s.
  - Edge flop irq_d<=irq_s.
  - pending is set when irq_s & ~irq_d; it is cleared only by int_taken or reset.
  - A new edge in the same cycle as int_taken leaves pending=1 (set wins).
  - intr = pending & MIE & MEIE, combinational from registers.
  - Latency from an irq_async rise (meeting setup) to intr=1 is SYNC_STAGES+1 edges, given MIE=MEIE=1.
  - pending set while MIE=0 is held; intr asserts the cycle after software sets MIE.
  - irq_async already high at reset release is detected as an edge.
  - A level held high produces exactly one pending event.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- Defined:
  - 64-bit mcycle counter, +1 every cycle, wraps at 2^64-1 to 0, reset to 0.
  - Readable at 0xB00 (low word) and 0xB80 (high word).
  - A CSR write to either half replaces that half; the counter does not increment in the write cycle.
- Undefined: 0xB00 and 0xB80 are unmapped (read 0, writes ignored).

Decomposition:
- Package csr_pkg:
  - CSR address localparams;
  - mstatus bit-index constants;
  - MCAUSE_MEXT constant (32'h8000_000B);
  - enum for func3[1:0] CSR operation.
- One sub-module, irq_sync_edge: parameterised synchronizer plus rising-edge detector, output pulse irq_rise.

Test Plan:
- Reset; read all CSRs -> mtvec=MTVEC_RESET, all others 0, intr=0.
- csrrw 0x305 wdata=32'h0000_1003 -> next-cycle mtvec_out=32'h0000_1000; csr_rd in the write cycle shows the old value.
- Write mstatus=0x8, set mie bit 11; pulse irq_async -> intr=1 exactly 3 edges later (SYNC_STAGES=2).
- With intr=1, pc=32'h0000_0040, int_taken=1 -> mepc=0x40, mcause=32'h8000_000B, MIE=0, MPIE=1, intr=0.
- mret_exec=1 after entry -> MIE=1, MPIE=1. Same-cycle csr_WE to mstatus with int_taken -> the write is dropped.
- irq edge while MIE=0 -> mip bit 11 reads 1, intr=0. Set MIE -> intr=1 next cycle. Assert RST_N=0 -> pending cleared.
